rlink_tx_sched: RTL and testbench

RLINK_TX_SCHED -- requirements
Module: rlink_tx_sched

---
 rtl/rlink_tx_sched_pkg.sv | 15 +
 rtl/rlink_rr_arb.sv | 46 ++++
 rtl/rlink_tx_sched.sv | 94 +++++++++
 tb/tb_rlink_tx_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rlink_tx_sched_pkg.sv
// Shared router definitions for the R-link TX scheduler: link state encoding
// and the link-flit constant sent while returning credits.
package rlink_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_STOP   = 2'b00,
    ST_RUN    = 2'b01,
    ST_RETURN = 2'b10
  } tx_state_e;

  // Sized generously so any supported FLIT_W can take a low slice of it.
  localparam int                    LINK_FLIT_MAX_W = 1024;
  localparam logic [LINK_FLIT_MAX_W-1:0] LINK_FLIT  = '0;

endpackage

// File: rtl/rlink_rr_arb.sv
// Round-robin arbiter: one-hot grant from req, pointer moves to one past the
// winner whenever advance is high and something won.
module rlink_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic               clock,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic             found;
  int               idx;

  // Scan from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win_idx  = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (advance && found) begin
      if (win_idx == PTR_W'(NUM_REQ - 1)) ptr <= '0;
      else                                ptr <= win_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/rlink_tx_sched.sv
// R-link TX flit scheduler: arbitrates requesters onto the TX flit channel
// against L-credits and returns leftover credits as link flits on deactivate.
module rlink_tx_sched
  import rlink_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = 128,
  parameter int MAX_CRD = 15,
  parameter int CRD_W   = $clog2(MAX_CRD + 1)
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic                      txla_run,
  input  logic                      txla_deactivate,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      txlcrdv,
  output logic                      txflitpend,
  output logic                      txflitv,
  output logic [FLIT_W-1:0]         txflit,
  output logic                      flit2send,
  output logic [CRD_W-1:0]          crd_cnt,
  output logic                      crd_ovf,
  output logic                      ret_done
);

  tx_state_e          state;
  logic               grant_ok;
  logic               ret_consume;
  logic               consume;
  logic [NUM_REQ-1:0] arb_req;
  logic [FLIT_W-1:0]  sel_flit;

  // Credits arriving this cycle are not usable until the next one.
  assign grant_ok    = (state == ST_RUN) && (|req) && (crd_cnt != '0);
  assign ret_consume = (state == ST_RETURN) && (crd_cnt != '0);
  assign consume     = grant_ok | ret_consume;
  assign txflitpend  = consume;
  assign flit2send   = |req;
  assign ret_done    = (state == ST_RETURN) && (crd_cnt == '0) && !txlcrdv;
  assign arb_req     = grant_ok ? req : '0;

  rlink_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clock   (clock),
    .rstn    (rstn),
    .req     (arb_req),
    .advance (grant_ok),
    .gnt     (gnt)
  );

  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel_flit = sel_flit | req_flit[i*FLIT_W +: FLIT_W];
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_STOP;
      crd_cnt <= '0;
      crd_ovf <= 1'b0;
      txflitv <= 1'b0;
      txflit  <= '0;
    end else begin
      case (state)
        ST_STOP:   if (txla_run) state <= ST_RUN;
        ST_RUN: begin
          if (txla_deactivate) state <= ST_RETURN;
          else if (!txla_run)  state <= ST_STOP;
        end
        ST_RETURN: if (ret_done) state <= ST_STOP;
        default:   state <= ST_STOP;
      endcase

      // A credit received while one is consumed leaves the count unchanged.
      if (txlcrdv && !consume) begin
        if (crd_cnt == CRD_W'(MAX_CRD)) crd_ovf <= 1'b1;
        else                            crd_cnt <= crd_cnt + CRD_W'(1);
      end else if (!txlcrdv && consume) begin
        crd_cnt <= crd_cnt - CRD_W'(1);
      end

      txflitv <= consume;
      if (grant_ok)         txflit <= sel_flit;
      else if (ret_consume) txflit <= LINK_FLIT[FLIT_W-1:0];
      else                  txflit <= '0;
    end
  end

endmodule

// File: tb/tb_rlink_tx_sched.sv
// Directed bench for rlink_tx_sched: a vector table for the grant/return flow
// plus hand sequences for overflow, same-cycle credit, reset and return corners.
module tb_rlink_tx_sched;
  import rlink_tx_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int FLIT_W  = 128;
  localparam int CRD_W   = 4;

  logic                      clock;
  logic                      rstn;
  logic                      txla_run;
  logic                      txla_deactivate;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*FLIT_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        gnt;
  logic                      txlcrdv;
  logic                      txflitpend;
  logic                      txflitv;
  logic [FLIT_W-1:0]         txflit;
  logic                      flit2send;
  logic [CRD_W-1:0]          crd_cnt;
  logic                      crd_ovf;
  logic                      ret_done;

  int n_cmp  = 0;
  int n_fail = 0;

  rlink_tx_sched #(
    .NUM_REQ (NUM_REQ),
    .FLIT_W  (FLIT_W),
    .MAX_CRD (15)
  ) dut (
    .clock           (clock),
    .rstn            (rstn),
    .txla_run        (txla_run),
    .txla_deactivate (txla_deactivate),
    .req             (req),
    .req_flit        (req_flit),
    .gnt             (gnt),
    .txlcrdv         (txlcrdv),
    .txflitpend      (txflitpend),
    .txflitv         (txflitv),
    .txflit          (txflit),
    .flit2send       (flit2send),
    .crd_cnt         (crd_cnt),
    .crd_ovf         (crd_ovf),
    .ret_done        (ret_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic               run;
    logic               deact;
    logic [NUM_REQ-1:0] req;
    logic               crdv;
    logic [NUM_REQ-1:0] gnt;
    logic               pend;
    logic               v;
    int                 fsel;
    logic [CRD_W-1:0]   crd;
    logic               ret;
    logic               f2s;
    tx_state_e          st;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [FLIT_W-1:0] flit_of(input int i);
    if (i < 0) return '0;
    return FLIT_W'(i + 1) * 128'h0001_0001_0001_0001_0001_0001_0001_0001;
  endfunction

  function automatic vec_t mk(input logic run, input logic deact, input logic [3:0] r,
                              input logic crdv, input logic [3:0] g, input logic pend,
                              input logic v, input int fsel, input logic [3:0] crd,
                              input logic ret, input logic f2s, input tx_state_e st);
    vec_t t;
    t.run = run;  t.deact = deact; t.req = r;     t.crdv = crdv;
    t.gnt = g;    t.pend = pend;   t.v = v;       t.fsel = fsel;
    t.crd = crd;  t.ret = ret;     t.f2s = f2s;   t.st = st;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic run, input logic deact,
                                input logic [NUM_REQ-1:0] r, input logic crdv);
    txla_run        = run;
    txla_deactivate = deact;
    req             = r;
    txlcrdv         = crdv;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) req_flit[i*FLIT_W +: FLIT_W] = flit_of(i);
    rstn = 1'b0;
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);

    // Table: credits arrive, 0011 granted round-robin, then deactivate and return.
    tbl[0]  = mk(1,0,4'b0000,0, 4'b0000,0,0,-1, 0,0,0,ST_STOP);
    tbl[1]  = mk(1,0,4'b0000,1, 4'b0000,0,0,-1, 0,0,0,ST_RUN);
    tbl[2]  = mk(1,0,4'b0000,1, 4'b0000,0,0,-1, 1,0,0,ST_RUN);
    tbl[3]  = mk(1,0,4'b0000,1, 4'b0000,0,0,-1, 2,0,0,ST_RUN);
    tbl[4]  = mk(1,0,4'b0011,0, 4'b0001,1,0,-1, 3,0,1,ST_RUN);
    tbl[5]  = mk(1,0,4'b0011,0, 4'b0010,1,1, 0, 2,0,1,ST_RUN);
    tbl[6]  = mk(1,0,4'b0011,0, 4'b0001,1,1, 1, 1,0,1,ST_RUN);
    tbl[7]  = mk(1,0,4'b0011,0, 4'b0000,0,1, 0, 0,0,1,ST_RUN);
    tbl[8]  = mk(1,0,4'b0011,0, 4'b0000,0,0,-1, 0,0,1,ST_RUN);
    tbl[9]  = mk(1,0,4'b0011,1, 4'b0000,0,0,-1, 0,0,1,ST_RUN);
    tbl[10] = mk(1,0,4'b0011,0, 4'b0010,1,0,-1, 1,0,1,ST_RUN);
    tbl[11] = mk(1,0,4'b0000,0, 4'b0000,0,1, 1, 0,0,0,ST_RUN);
    tbl[12] = mk(1,0,4'b0000,1, 4'b0000,0,0,-1, 0,0,0,ST_RUN);
    tbl[13] = mk(1,0,4'b0000,1, 4'b0000,0,0,-1, 1,0,0,ST_RUN);
    tbl[14] = mk(0,1,4'b0000,0, 4'b0000,0,0,-1, 2,0,0,ST_RUN);
    tbl[15] = mk(0,1,4'b1000,0, 4'b0000,1,0,-1, 2,0,1,ST_RETURN);
    tbl[16] = mk(0,1,4'b1000,0, 4'b0000,1,1,-1, 1,0,1,ST_RETURN);
    tbl[17] = mk(0,1,4'b1000,0, 4'b0000,0,1,-1, 0,1,1,ST_RETURN);
    tbl[18] = mk(0,0,4'b1000,0, 4'b0000,0,0,-1, 0,0,1,ST_STOP);

    #3;
    check_output("reset txflitv",    128'(txflitv),    128'(0));
    check_output("reset txflit",     128'(txflit),     128'(0));
    check_output("reset crd_cnt",    128'(crd_cnt),    128'(0));
    check_output("reset crd_ovf",    128'(crd_ovf),    128'(0));
    check_output("reset gnt",        128'(gnt),        128'(0));
    check_output("reset txflitpend", 128'(txflitpend), 128'(0));
    check_output("reset ret_done",   128'(ret_done),   128'(0));
    check_output("reset state",      128'(dut.state),  128'(ST_STOP));
    next_cycle();
    rstn = 1'b1;

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(tbl[i].run, tbl[i].deact, tbl[i].req, tbl[i].crdv);
      @(negedge clock);
      check_output($sformatf("row%0d gnt", i),        128'(gnt),        128'(tbl[i].gnt));
      check_output($sformatf("row%0d txflitpend", i), 128'(txflitpend), 128'(tbl[i].pend));
      check_output($sformatf("row%0d txflitv", i),    128'(txflitv),    128'(tbl[i].v));
      check_output($sformatf("row%0d txflit", i),     128'(txflit),     128'(flit_of(tbl[i].fsel)));
      check_output($sformatf("row%0d crd_cnt", i),    128'(crd_cnt),    128'(tbl[i].crd));
      check_output($sformatf("row%0d ret_done", i),   128'(ret_done),   128'(tbl[i].ret));
      check_output($sformatf("row%0d flit2send", i),  128'(flit2send),  128'(tbl[i].f2s));
      check_output($sformatf("row%0d state", i),      128'(dut.state),  128'(tbl[i].st));
      next_cycle();
    end

    // Saturation at MAX_CRD sets a sticky overflow flag.
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(1'b0, 1'b0, '0, 1'b1);
      next_cycle();
    end
    check_output("sat crd_cnt at 15", 128'(crd_cnt), 128'(15));
    check_output("sat ovf before",    128'(crd_ovf), 128'(0));
    next_cycle();
    check_output("sat crd_cnt held", 128'(crd_cnt), 128'(15));
    check_output("sat ovf set",      128'(crd_ovf), 128'(1));
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_output($sformatf("sat ovf sticky%0d", i), 128'(crd_ovf), 128'(1));
      check_output($sformatf("sat crd idle%0d", i),   128'(crd_cnt), 128'(15));
    end

    // Grant and credit arrival in the same cycle.
    reset_dut();
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 4'b0100, 1'b1);
    @(negedge clock);
    check_output("same gnt1", 128'(gnt),     128'(4'b0100));
    check_output("same crd1", 128'(crd_cnt), 128'(1));
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 4'b0100, 1'b0);
    @(negedge clock);
    check_output("same crd kept", 128'(crd_cnt), 128'(1));
    check_output("same gnt2",     128'(gnt),     128'(4'b0100));
    check_output("same txflitv",  128'(txflitv), 128'(1));
    check_output("same txflit",   128'(txflit),  128'(flit_of(2)));
    next_cycle();
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clock);
    check_output("same crd0",     128'(crd_cnt), 128'(0));
    check_output("same gnt none", 128'(gnt),     128'(0));
    check_output("same txflitv2", 128'(txflitv), 128'(1));
    next_cycle();

    // Reset asserted right after a grant discards the in-flight flit.
    reset_dut();
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 4'b0001, 1'b0);
    @(negedge clock);
    check_output("rst gnt", 128'(gnt), 128'(4'b0001));
    rstn = 1'b0;
    #1;
    check_output("rst crd async",   128'(crd_cnt),   128'(0));
    check_output("rst state async", 128'(dut.state), 128'(ST_STOP));
    next_cycle();
    check_output("rst txflitv", 128'(txflitv), 128'(0));
    check_output("rst txflit",  128'(txflit),  128'(0));
    rstn = 1'b1;
    apply_stimulus(1'b0, 1'b0, 4'b0001, 1'b0);
    @(negedge clock);
    check_output("rst post gnt",   128'(gnt),        128'(0));
    check_output("rst post pend",  128'(txflitpend), 128'(0));
    check_output("rst post f2s",   128'(flit2send),  128'(1));
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 4'b0001, 1'b0);
    next_cycle();
    check_output("rst run nocrd gnt", 128'(gnt),     128'(0));
    check_output("rst run nocrd v",   128'(txflitv), 128'(0));

    // Credit arriving during RETURN is returned before ret_done.
    reset_dut();
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, 1'b1, '0, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 1'b1, '0, 1'b1);
    @(negedge clock);
    check_output("ret c1 state", 128'(dut.state),  128'(ST_RETURN));
    check_output("ret c1 pend",  128'(txflitpend), 128'(1));
    check_output("ret c1 done",  128'(ret_done),   128'(0));
    next_cycle();
    apply_stimulus(1'b0, 1'b1, '0, 1'b0);
    @(negedge clock);
    check_output("ret c2 crd",  128'(crd_cnt),    128'(1));
    check_output("ret c2 pend", 128'(txflitpend), 128'(1));
    check_output("ret c2 v",    128'(txflitv),    128'(1));
    check_output("ret c2 done", 128'(ret_done),   128'(0));
    next_cycle();
    @(negedge clock);
    check_output("ret c3 v",     128'(txflitv),  128'(1));
    check_output("ret c3 flit",  128'(txflit),   128'(0));
    check_output("ret c3 done",  128'(ret_done), 128'(1));
    next_cycle();
    check_output("ret end state", 128'(dut.state), 128'(ST_STOP));
    check_output("ret end v",     128'(txflitv),   128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
